// File: rtl/dcache_uncached_bridge.sv
// Uncached responder for the pipeline data-cache request port: one SRAM-like bus access per request.
// Optional DCACHE_BRIDGE_TIMEOUT_EN adds a REQ/WAIT watchdog that forces a 32'hDEADBEEF response.
module dcache_uncached_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] dcache_idx,
  input  logic [4:0]  dcache_op,
  input  logic [1:0]  dcache_byte_type,
  input  logic        dcache_is_cached,
  input  logic [31:0] dcache_pa,
  input  logic [31:0] wr_dcache_data,
  input  logic        stall_dcache,
  output logic        dcache_busy,
  output logic        dcache_data_valid,
  output logic [31:0] rd_dcache_data,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t      state, state_nxt;
  logic        capture;
  logic        data_done;
  logic        timeout_hit;
  logic        cap_store;
  logic [1:0]  cap_size;
  logic [31:0] cap_addr;
  logic [3:0]  cap_strb;
  logic [31:0] cap_wdata;
  logic [31:0] rd_shifted;
  logic [31:0] load_data;

  logic        bus_wr_q;
  logic [1:0]  bus_size_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_wstrb_q;
  logic [31:0] bus_wdata_q;
  logic [31:0] rd_data_q;
  logic        timeout_q;

  // Index and cacheability hint are meaningless to an always-uncached bridge.
  logic unused_inputs;
  assign unused_inputs = ^{dcache_idx, dcache_is_cached};

  assign capture   = (state == S_IDLE) && ((dcache_op == 5'd1) || (dcache_op == 5'd2));
  assign data_done = (state == S_WAIT) && bus_data_ok;

  // Request decode: align the address down to the access size and build lanes/strobes.
  always_comb begin
    cap_store = (dcache_op == 5'd2);
    cap_size  = (dcache_byte_type == 2'd3) ? 2'd2 : dcache_byte_type;
    cap_addr  = dcache_pa;
    cap_strb  = 4'hF;
    cap_wdata = wr_dcache_data;
    case (cap_size)
      2'd0: begin
        cap_addr  = dcache_pa;
        cap_strb  = 4'b0001 << dcache_pa[1:0];
        cap_wdata = {4{wr_dcache_data[7:0]}};
      end
      2'd1: begin
        cap_addr  = {dcache_pa[31:1], 1'b0};
        cap_strb  = 4'b0011 << {dcache_pa[1], 1'b0};
        cap_wdata = {2{wr_dcache_data[15:0]}};
      end
      default: begin
        cap_addr  = {dcache_pa[31:2], 2'b00};
        cap_strb  = 4'hF;
        cap_wdata = wr_dcache_data;
      end
    endcase
    if (!cap_store) begin
      cap_strb = '0;
    end
  end

  // Return path: move the addressed bytes down to [7:0] and zero the unused upper bits.
  always_comb begin
    rd_shifted = bus_rdata >> {bus_addr_q[1:0], 3'b000};
    case (bus_size_q)
      2'd0:    load_data = {24'd0, rd_shifted[7:0]};
      2'd1:    load_data = {16'd0, rd_shifted[15:0]};
      default: load_data = rd_shifted;
    endcase
  end

`ifdef DCACHE_BRIDGE_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  // Fires on the cycle whose edge would bring the count to TIMEOUT_CYCLES; a same-cycle data_ok wins.
  assign timeout_hit = ((state == S_REQ) || (state == S_WAIT)) && !data_done &&
                       (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (capture) begin
        tmo_cnt <= '0;
      end else if ((state == S_REQ) || (state == S_WAIT)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES != 0);
  assign timeout_hit = 1'b0;
  assign timeout_q   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (capture) state_nxt = S_REQ;
      S_REQ: begin
        if (timeout_hit)      state_nxt = S_RESP;
        else if (bus_addr_ok) state_nxt = S_WAIT;
      end
      S_WAIT: if (data_done || timeout_hit) state_nxt = S_RESP;
      S_RESP: if (!stall_dcache) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      bus_wr_q    <= 1'b0;
      bus_size_q  <= '0;
      bus_addr_q  <= '0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        bus_wr_q    <= cap_store;
        bus_size_q  <= cap_size;
        bus_addr_q  <= cap_addr;
        bus_wstrb_q <= cap_strb;
        bus_wdata_q <= cap_wdata;
      end
      if (data_done) begin
        rd_data_q <= bus_wr_q ? '0 : load_data;
      end else if (timeout_hit) begin
        rd_data_q <= 32'hDEADBEEF;
      end
    end
  end

  assign dcache_busy       = (state != S_IDLE);
  assign dcache_data_valid = (state == S_RESP);
  assign rd_dcache_data    = rd_data_q;
  assign bus_req           = (state == S_REQ);
  assign bus_wr            = bus_wr_q;
  assign bus_size          = bus_size_q;
  assign bus_addr          = bus_addr_q;
  assign bus_wstrb         = bus_wstrb_q;
  assign bus_wdata         = bus_wdata_q;
  assign timeout_err       = timeout_q;

endmodule

// File: tb/tb_dcache_uncached_bridge.sv
// Directed self-checking bench for dcache_uncached_bridge; build with DCACHE_BRIDGE_TIMEOUT_EN to cover the watchdog.
`timescale 1ns/1ps
module tb_dcache_uncached_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] dcache_idx;
  logic [4:0]  dcache_op;
  logic [1:0]  dcache_byte_type;
  logic        dcache_is_cached;
  logic [31:0] dcache_pa;
  logic [31:0] wr_dcache_data;
  logic        stall_dcache;
  logic        dcache_busy;
  logic        dcache_data_valid;
  logic [31:0] rd_dcache_data;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  dcache_uncached_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .dcache_idx(dcache_idx), .dcache_op(dcache_op),
    .dcache_byte_type(dcache_byte_type), .dcache_is_cached(dcache_is_cached),
    .dcache_pa(dcache_pa), .wr_dcache_data(wr_dcache_data), .stall_dcache(stall_dcache),
    .dcache_busy(dcache_busy), .dcache_data_valid(dcache_data_valid),
    .rd_dcache_data(rd_dcache_data), .bus_req(bus_req), .bus_wr(bus_wr),
    .bus_size(bus_size), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns one edge later with the DUT in REQ.
  task automatic issue(input logic [4:0] op, input logic [1:0] bt, input logic [31:0] pa,
                       input logic [31:0] wd);
    dcache_op = op; dcache_byte_type = bt; dcache_pa = pa; wr_dcache_data = wd;
    dcache_idx = pa[11:0]; dcache_is_cached = 1'b1;
    tick();
    dcache_op = 5'd0;
  endtask

  task automatic grant_addr(input int unsigned delay);
    for (int unsigned i = 0; i < delay; i++) tick();
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
  endtask

  task automatic give_data(input logic [31:0] rdata);
    bus_data_ok = 1'b1; bus_rdata = rdata;
    tick();
    bus_data_ok = 1'b0; bus_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; dcache_op = '0; dcache_byte_type = '0; dcache_pa = '0; wr_dcache_data = '0;
    dcache_idx = '0; dcache_is_cached = 1'b0; stall_dcache = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (dcache_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", dcache_busy); end
    checks++; if (dcache_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dcache_data_valid); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus_req); end
    checks++; if ({bus_addr, bus_wdata, rd_dcache_data} !== 96'd0) begin errors++; $display("FAIL reset_data got %h %h %h exp 0", bus_addr, bus_wdata, rd_dcache_data); end
    checks++; if ({bus_wr, bus_size, bus_wstrb, timeout_err} !== 8'd0) begin errors++; $display("FAIL reset_ctl got %b%b%b%b exp 0", bus_wr, bus_size, bus_wstrb, timeout_err); end
    dcache_op = 5'd7;
    tick();
    checks++; if (dcache_busy !== 1'b0) begin errors++; $display("FAIL unknown_op_busy got %b exp 0", dcache_busy); end
    dcache_op = 5'd0;
  endtask

  task automatic test_word_load();
    issue(5'd1, 2'd2, 32'h1C000104, 32'h0);
    checks++; if ({dcache_busy, bus_req, bus_wr} !== 3'b110) begin errors++; $display("FAIL wl_req got %b exp 110", {dcache_busy, bus_req, bus_wr}); end
    checks++; if (bus_addr !== 32'h1C000104 || bus_size !== 2'd2 || bus_wstrb !== 4'h0) begin errors++; $display("FAIL wl_fields got %h %0d %b exp 1c000104 2 0000", bus_addr, bus_size, bus_wstrb); end
    tick();
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h1C000104) begin errors++; $display("FAIL wl_req_hold got %b %h exp 1 1c000104", bus_req, bus_addr); end
    grant_addr(1);
    checks++; if ({dcache_busy, bus_req, dcache_data_valid} !== 3'b100) begin errors++; $display("FAIL wl_wait got %b exp 100", {dcache_busy, bus_req, dcache_data_valid}); end
    give_data(32'hAABBCCDD);
    checks++; if (dcache_data_valid !== 1'b1 || dcache_busy !== 1'b1) begin errors++; $display("FAIL wl_resp got %b%b exp 11", dcache_data_valid, dcache_busy); end
    checks++; if (rd_dcache_data !== 32'hAABBCCDD) begin errors++; $display("FAIL wl_data got %h exp aabbccdd", rd_dcache_data); end
    tick();
    checks++; if (dcache_data_valid !== 1'b0 || dcache_busy !== 1'b0) begin errors++; $display("FAIL wl_idle got %b%b exp 00", dcache_data_valid, dcache_busy); end
  endtask

  task automatic test_stores();
    issue(5'd2, 2'd0, 32'h1C000203, 32'h0000005A);
    checks++; if (bus_addr !== 32'h1C000203 || bus_size !== 2'd0 || bus_wr !== 1'b1) begin errors++; $display("FAIL bs_fields got %h %0d %b exp 1c000203 0 1", bus_addr, bus_size, bus_wr); end
    checks++; if (bus_wstrb !== 4'b1000 || bus_wdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL bs_lanes got %b %h exp 1000 5a5a5a5a", bus_wstrb, bus_wdata); end
    grant_addr(0);
    give_data(32'hFFFFFFFF);
    checks++; if (dcache_data_valid !== 1'b1 || rd_dcache_data !== 32'h0) begin errors++; $display("FAIL bs_resp got %b %h exp 1 00000000", dcache_data_valid, rd_dcache_data); end
    tick();
    issue(5'd2, 2'd1, 32'h1C000013, 32'h1234BEEF);
    checks++; if (bus_addr !== 32'h1C000012 || bus_wstrb !== 4'b1100 || bus_wdata !== 32'hBEEFBEEF) begin errors++; $display("FAIL hs_fields got %h %b %h exp 1c000012 1100 beefbeef", bus_addr, bus_wstrb, bus_wdata); end
    grant_addr(0); give_data(32'h0); tick();
    issue(5'd2, 2'd3, 32'h1C000023, 32'hCAFEF00D);
    checks++; if (bus_addr !== 32'h1C000020 || bus_size !== 2'd2 || bus_wstrb !== 4'hF || bus_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL ws_fields got %h %0d %b %h exp 1c000020 2 1111 cafef00d", bus_addr, bus_size, bus_wstrb, bus_wdata); end
    grant_addr(0); give_data(32'h0); tick();
  endtask

  task automatic test_sub_word_load();
    issue(5'd1, 2'd1, 32'h1C000006, 32'h0);
    checks++; if (bus_addr !== 32'h1C000006 || bus_size !== 2'd1 || bus_wstrb !== 4'h0) begin errors++; $display("FAIL hl_fields got %h %0d %b exp 1c000006 1 0000", bus_addr, bus_size, bus_wstrb); end
    grant_addr(0); give_data(32'h1234ABCD);
    checks++; if (rd_dcache_data !== 32'h00001234) begin errors++; $display("FAIL hl_hi got %h exp 00001234", rd_dcache_data); end
    tick();
    issue(5'd1, 2'd1, 32'h1C000004, 32'h0);
    grant_addr(0); give_data(32'h1234ABCD);
    checks++; if (rd_dcache_data !== 32'h0000ABCD) begin errors++; $display("FAIL hl_lo got %h exp 0000abcd", rd_dcache_data); end
    tick();
    issue(5'd1, 2'd1, 32'h1C000007, 32'h0);
    checks++; if (bus_addr !== 32'h1C000006) begin errors++; $display("FAIL hl_misalign got %h exp 1c000006", bus_addr); end
    grant_addr(0); give_data(32'h0); tick();
    issue(5'd1, 2'd0, 32'h1C000001, 32'h0);
    grant_addr(0); give_data(32'h1234ABCD);
    checks++; if (rd_dcache_data !== 32'h000000AB) begin errors++; $display("FAIL bl_off1 got %h exp 000000ab", rd_dcache_data); end
    tick();
  endtask

  task automatic test_stall();
    issue(5'd1, 2'd2, 32'h1C000100, 32'h0);
    grant_addr(0);
    give_data(32'h13572468);
    stall_dcache = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({dcache_data_valid, dcache_busy} !== 2'b11 || rd_dcache_data !== 32'h13572468) begin errors++; $display("FAIL stall_hold%0d got %b%b %h exp 11 13572468", i, dcache_data_valid, dcache_busy, rd_dcache_data); end
      if (i == 2) dcache_op = 5'd0;
      if (i < 3) tick();
    end
    stall_dcache = 1'b0;
    dcache_op = 5'd1; dcache_byte_type = 2'd2; dcache_pa = 32'h1C000300;
    tick();
    checks++; if ({dcache_busy, dcache_data_valid} !== 2'b00) begin errors++; $display("FAIL stall_release got %b%b exp 00", dcache_busy, dcache_data_valid); end
    tick();
    dcache_op = 5'd0;
    checks++; if (dcache_busy !== 1'b1 || bus_req !== 1'b1 || bus_addr !== 32'h1C000300) begin errors++; $display("FAIL stall_next_cap got %b %b %h exp 1 1 1c000300", dcache_busy, bus_req, bus_addr); end
    grant_addr(0); give_data(32'h0); tick();
  endtask

  task automatic test_reset_mid();
    issue(5'd1, 2'd2, 32'h1C000400, 32'h0);
    grant_addr(0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({bus_req, dcache_busy, dcache_data_valid} !== 3'b000) begin errors++; $display("FAIL rst_mid got %b exp 000", {bus_req, dcache_busy, dcache_data_valid}); end
    give_data(32'h99999999);
    checks++; if ({dcache_busy, dcache_data_valid} !== 2'b00 || rd_dcache_data !== 32'h0) begin errors++; $display("FAIL rst_late_data got %b%b %h exp 00 00000000", dcache_busy, dcache_data_valid, rd_dcache_data); end
  endtask

  task automatic test_timeout();
    int first = 0;
    logic [31:0] rd_at = '0;
    logic valid_at = 1'b0, req_at = 1'b1;
    issue(5'd1, 2'd2, 32'h1C000500, 32'h0);
`ifdef DCACHE_BRIDGE_TIMEOUT_EN
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (timeout_err === 1'b1 && first == 0) begin
        first = k; rd_at = rd_dcache_data; valid_at = dcache_data_valid; req_at = bus_req;
        bus_data_ok = 1'b1; bus_rdata = 32'h11111111;
      end else begin
        bus_data_ok = 1'b0;
      end
    end
    checks++; if (first != 8) begin errors++; $display("FAIL tmo_cycle got %0d exp 8", first); end
    checks++; if (rd_at !== 32'hDEADBEEF || valid_at !== 1'b1 || req_at !== 1'b0) begin errors++; $display("FAIL tmo_resp got %h %b %b exp deadbeef 1 0", rd_at, valid_at, req_at); end
    checks++; if (dcache_busy !== 1'b0 || timeout_err !== 1'b0 || rd_dcache_data !== 32'hDEADBEEF) begin errors++; $display("FAIL tmo_after got %b %b %h exp 0 0 deadbeef", dcache_busy, timeout_err, rd_dcache_data); end
`else
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (timeout_err !== 1'b0 && first == 0) first = k;
    end
    checks++; if (first != 0) begin errors++; $display("FAIL notmo_pulse got cycle %0d exp none", first); end
    checks++; if ({dcache_busy, bus_req, dcache_data_valid} !== 3'b110) begin errors++; $display("FAIL notmo_wait got %b exp 110", {dcache_busy, bus_req, dcache_data_valid}); end
    grant_addr(0); give_data(32'h2468ACE0);
    checks++; if (rd_dcache_data !== 32'h2468ACE0 || dcache_data_valid !== 1'b1) begin errors++; $display("FAIL notmo_done got %h %b exp 2468ace0 1", rd_dcache_data, dcache_data_valid); end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_stores();
    test_sub_word_load();
    test_stall();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_uncached_bridge.md
Name: dcache_uncached_bridge

Overview:
- Responder end of the pipeline's data-cache request interface.
- Mem1 issues an op, byte type, physical address and store data. The bridge performs the access on an SRAM-like memory bus, holds busy while the access is outstanding, and returns load data with data_valid for mem2.
- Every access is treated as uncached. It is the first memory-side block, ahead of a real cache.

Parameters:
TIMEOUT_CYCLES, 255, cycles in REQ+WAIT before a forced error response (used only with DCACHE_BRIDGE_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
dcache_idx  in  12  virtual index; ignored by this block
dcache_op  in  5  0=NOP, 1=LOAD, 2=STORE, others treated as NOP
dcache_byte_type  in  2  0=byte, 1=half, 2=word, 3 treated as word
dcache_is_cached  in  1  ignored; all accesses are uncached
dcache_pa  in  32  physical address
wr_dcache_data  in  32  store data, right-aligned
stall_dcache  in  1  downstream stall; holds the response
dcache_busy  out  1  request cannot be accepted
dcache_data_valid  out  1  response valid
rd_dcache_data  out  32  load data, addressed bytes at [7:0]
bus_req  out  1  bus request
bus_wr  out  1  1=write
bus_size  out  2  0=byte, 1=half, 2=word
bus_addr  out  32  bus address
bus_wstrb  out  4  byte strobes
bus_wdata  out  32  replicated write data
bus_addr_ok  in  1  request accepted
bus_data_ok  in  1  read data or write ack
bus_rdata  in  32  read data
timeout_err  out  1  one-cycle timeout flag

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, every output 0, counter 0. Reset mid-transaction abandons the access; the bus is reset together with the bridge.
- dcache_busy = (state != IDLE), combinational from state.
- IDLE
  - A LOAD or STORE op is captured at the posedge. Captured fields: op, byte type, pa, data.
  - Next state is REQ, so busy=1 in the following cycle.
  - NOP or unknown op: no state change and no data_valid.
- Capture-time address and data rules:
  - Address is aligned down per size: half clears pa[0], word clears pa[1:0].
  - bus_size equals the byte type, with 3 mapped to 2.
  - wstrb: byte=4'b0001<<pa[1:0]; half=4'b0011<<{pa[1],1'b0}; word=4'hF.
  - wdata: byte replicated x4, half replicated x2, word as-is.
  - For a LOAD, wstrb=0.
- REQ
  - Drives bus_req=1 plus the registered bus fields.
  - On bus_addr_ok=1, goes to WAIT and drops bus_req the next cycle.
  - bus fields stay stable while bus_req=1.
- WAIT
  - On bus_data_ok=1, data is registered. LOAD: bus_rdata >> (8*aligned pa[1:0]), with the upper unused bits zeroed (byte keeps [7:0], half keeps [15:0]); sign extension is done by the pipeline. STORE: data is 0.
  - Next state is RESP.
  - bus_data_ok in REQ is ignored; the bus protocol forbids data before addr.
- RESP
  - dcache_data_valid=1 and rd_dcache_data stable.
  - stall_dcache=1: stays in RESP, with data_valid and data held.
  - stall_dcache=0: goes to IDLE, and data_valid falls next cycle.
  - A new request can be captured no earlier than the cycle after RESP.
- Latency with zero-wait bus:
  - capture → REQ (T+1)
  - addr_ok → WAIT (T+2)
  - data_ok → RESP (T+3)
  - data_valid high at T+3
- Misaligned requests are silently aligned down; mem1 raises ALE before issuing.
- Only one access is outstanding at a time. Writes are never posted; a store completes only after data_ok.

Optional Feature:
- Macro: DCACHE_BRIDGE_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter runs from 0 on entry to REQ and increments each cycle in REQ/WAIT.
  - When the counter reaches TIMEOUT_CYCLES without data_ok: goes to RESP with rd_dcache_data=32'hDEADBEEF, pulses timeout_err for 1 cycle and drops bus_req.
  - A late bus_data_ok after timeout is ignored.
- Undefined: the counter is absent, timeout_err is tied 0, and the bridge waits indefinitely.

Test Plan:
- Word LOAD pa=0x1C000104, addr_ok 2 cycles after req, data_ok next cycle with rdata=0xAABBCCDD → bus_size=2, wstrb=0, rd_dcache_data=0xAABBCCDD with data_valid the cycle after data_ok; busy high from capture+1 through RESP.
- Byte STORE pa=0x1C000203, data=0x0000005A → bus_addr=0x1C000203, size=0, wstrb=4'b1000, wdata=0x5A5A5A5A, bus_wr=1; data_valid with data 0.
- Half LOAD pa=0x1C000006, rdata=0x1234ABCD → bus_addr=0x1C000006, rd_dcache_data=0x00001234; half at pa offset 0 → 0x0000ABCD.
- Stall: stall_dcache=1 for 3 cycles in RESP → data_valid and data held 4 cycles total, busy=1 throughout; a LOAD presented during RESP is not captured, then captured the cycle after IDLE.
- rst=1 while in WAIT → next cycle: bus_req=0, busy=0, data_valid=0, state IDLE; a later data_ok is ignored.
- With DCACHE_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=8, no data_ok → timeout_err pulse 8 cycles after REQ entry, rd_dcache_data=0xDEADBEEF with data_valid; without the macro, still waiting at cycle 100.
